drive_cmd_scheduler: RTL and testbench

//  Arbitrates the cart's motion sources and drives the 3-bit mode bus of the motor block.

---
 rtl/drive_cmd_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_drive_cmd_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/drive_cmd_scheduler.sv
// Motion-source arbiter for the cart: picks follow or speech targets, times speech turns,
// gates speech fwd/back on a safety distance and inserts stop dead-time between moves.
module drive_cmd_scheduler #(
   parameter int TURN_CYCLES = 8_388_608,
   parameter int DEAD_CYCLES = 1_000_000,
   parameter int NEAR_CM     = 15,
   parameter int FAR_CM      = 60,
   parameter int SAFE_CM     = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic [7:0]  cmd_data,
   input  logic [1:0]  sw,
   input  logic [19:0] distance,
   input  logic        ir_l,
   input  logic        ir_r,
   output logic [2:0]  mode,
   output logic [1:0]  src,
   output logic        busy,
   output logic        cmd_ack
);

   // state | meaning
   // STOP  | motor stopped, no target
   // RUN   | untimed move, mode follows target
   // TURN  | timed speech turn, busy high
   // DEAD  | forced stop between two different non-stop modes
   typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_TURN, ST_DEAD} state_t;

   localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
   localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);
   localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);

   localparam logic [19:0] NEAR_D = 20'(NEAR_CM);
   localparam logic [19:0] FAR_D  = 20'(FAR_CM);
   localparam logic [19:0] SAFE_D = 20'(SAFE_CM);

   localparam logic [2:0] M_STOP  = 3'b000;
   localparam logic [2:0] M_LEFT  = 3'b001;
   localparam logic [2:0] M_RIGHT = 3'b010;
   localparam logic [2:0] M_FWD   = 3'b011;
   localparam logic [2:0] M_BACK  = 3'b100;

   localparam logic [7:0] C_FWD    = 8'd111;
   localparam logic [7:0] C_BACK   = 8'd251;
   localparam logic [7:0] C_LEFT   = 8'd247;
   localparam logic [7:0] C_RIGHT  = 8'd255;
   localparam logic [7:0] C_FOLLOW = 8'd49;
   localparam logic [7:0] C_SPEECH = 8'd50;

   localparam logic [1:0] SRC_FOLLOW = 2'b01;
   localparam logic [1:0] SRC_SPEECH = 2'b10;

   state_t          state, state_nxt;
   logic [2:0]      spc_cmd, spc_nxt;
   logic [TW-1:0]   turn_cnt, turn_nxt;
   logic [DW-1:0]   dead_cnt, dead_nxt;
   logic [2:0]      mode_nxt;
   logic [1:0]      src_nxt;
   logic            src_chg;
   logic [2:0]      cmd_mode;
   logic            cmd_move;
   logic            cmd_recog;
   logic            spc_take;
   logic            new_turn;
   logic            win;
   logic            safe;
   logic [2:0]      follow_tgt;
   logic [2:0]      tgt;
   logic            tgt_turn;

   always_comb begin
      src_nxt = src;
      if (sw == SRC_FOLLOW || sw == SRC_SPEECH)
         src_nxt = sw;
      else if (cmd_valid && cmd_data == C_FOLLOW)
         src_nxt = SRC_FOLLOW;
      else if (cmd_valid && cmd_data == C_SPEECH)
         src_nxt = SRC_SPEECH;
      src_chg = (src_nxt != src);

      cmd_mode = M_STOP;
      case (cmd_data)
         C_FWD:   cmd_mode = M_FWD;
         C_BACK:  cmd_mode = M_BACK;
         C_LEFT:  cmd_mode = M_LEFT;
         C_RIGHT: cmd_mode = M_RIGHT;
         default: cmd_mode = M_STOP;
      endcase
      cmd_move  = cmd_valid && (cmd_mode != M_STOP);
      cmd_recog = cmd_move || (cmd_valid && (cmd_data == C_FOLLOW || cmd_data == C_SPEECH));
      spc_take  = (src == SRC_SPEECH) && !src_chg && cmd_valid &&
                  (cmd_data != C_FOLLOW) && (cmd_data != C_SPEECH);
      new_turn  = spc_take && (cmd_mode == M_LEFT || cmd_mode == M_RIGHT);

      win  = (distance > NEAR_D) && (distance < FAR_D);
      safe = (distance > SAFE_D);

      follow_tgt = M_STOP;
      if (win && ir_l && ir_r)
         follow_tgt = M_FWD;
      else if (win && ir_l)
         follow_tgt = M_LEFT;
      else if (win && ir_r)
         follow_tgt = M_RIGHT;

      // The latch is cleared by the safety stop so the cart does not restart on its own.
      spc_nxt = spc_cmd;
      if (src_chg)
         spc_nxt = M_STOP;
      else if (spc_take)
         spc_nxt = cmd_mode;
      else if (state == ST_TURN && turn_cnt == TURN_LAST)
         spc_nxt = M_STOP;
      if ((spc_nxt == M_FWD || spc_nxt == M_BACK) && !safe)
         spc_nxt = M_STOP;

      if (src_chg)
         tgt = M_STOP;
      else if (src == SRC_FOLLOW)
         tgt = follow_tgt;
      else
         tgt = spc_nxt;
      tgt_turn = (src == SRC_SPEECH) && (tgt == M_LEFT || tgt == M_RIGHT);
   end

   // In DEAD the live target is the pending mode, so the newest request wins at expiry.
   always_comb begin
      state_nxt = state;
      mode_nxt  = mode;
      turn_nxt  = turn_cnt;
      dead_nxt  = dead_cnt;
      case (state)
         ST_STOP: begin
            mode_nxt = M_STOP;
            if (tgt != M_STOP) begin
               state_nxt = tgt_turn ? ST_TURN : ST_RUN;
               mode_nxt  = tgt;
               turn_nxt  = '0;
            end
         end
         ST_RUN: begin
            if (tgt == M_STOP) begin
               state_nxt = ST_STOP;
               mode_nxt  = M_STOP;
            end else if (tgt != mode) begin
               state_nxt = ST_DEAD;
               mode_nxt  = M_STOP;
               dead_nxt  = '0;
            end
         end
         ST_TURN: begin
            if (tgt == M_STOP) begin
               state_nxt = ST_STOP;
               mode_nxt  = M_STOP;
            end else if (tgt != mode) begin
               state_nxt = ST_DEAD;
               mode_nxt  = M_STOP;
               dead_nxt  = '0;
            end else if (new_turn) begin
               turn_nxt = '0;
            end else begin
               turn_nxt = turn_cnt + TW'(1);
            end
         end
         ST_DEAD: begin
            mode_nxt = M_STOP;
            if (tgt == M_STOP) begin
               state_nxt = ST_STOP;
            end else if (dead_cnt == DEAD_LAST) begin
               state_nxt = tgt_turn ? ST_TURN : ST_RUN;
               mode_nxt  = tgt;
               turn_nxt  = '0;
            end else begin
               dead_nxt = dead_cnt + DW'(1);
            end
         end
         default: begin
            state_nxt = ST_STOP;
            mode_nxt  = M_STOP;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_STOP;
         mode     <= M_STOP;
         src      <= SRC_FOLLOW;
         busy     <= 1'b0;
         cmd_ack  <= 1'b0;
         spc_cmd  <= M_STOP;
         turn_cnt <= '0;
         dead_cnt <= '0;
      end else begin
         state    <= state_nxt;
         mode     <= mode_nxt;
         src      <= src_nxt;
         busy     <= (state_nxt == ST_TURN);
         cmd_ack  <= cmd_recog;
         spc_cmd  <= spc_nxt;
         turn_cnt <= turn_nxt;
         dead_cnt <= dead_nxt;
      end
   end

endmodule

// File: tb/tb_drive_cmd_scheduler.sv
// Directed bench for drive_cmd_scheduler with short turn/dead timers.
module tb_drive_cmd_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic [7:0]  cmd_data;
   logic [1:0]  sw;
   logic [19:0] distance;
   logic        ir_l;
   logic        ir_r;
   logic [2:0]  mode;
   logic [1:0]  src;
   logic        busy;
   logic        cmd_ack;

   int checks = 0;
   int errors = 0;

   drive_cmd_scheduler #(
      .TURN_CYCLES(8),
      .DEAD_CYCLES(4),
      .NEAR_CM(15),
      .FAR_CM(60),
      .SAFE_CM(20)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cmd_valid(cmd_valid),
      .cmd_data(cmd_data),
      .sw(sw),
      .distance(distance),
      .ir_l(ir_l),
      .ir_r(ir_r),
      .mode(mode),
      .src(src),
      .busy(busy),
      .cmd_ack(cmd_ack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present a command for exactly one sampling edge.
   task automatic send(input logic [7:0] code);
      cmd_valid = 1'b1;
      cmd_data  = code;
      tick();
      cmd_valid = 1'b0;
      cmd_data  = 8'd0;
   endtask

   initial begin
      rst = 1'b0; cmd_valid = 1'b0; cmd_data = 8'd0; sw = 2'b01;
      distance = 20'd30; ir_l = 1'b1; ir_r = 1'b1;
      ticks(2);
      chk("rst_mode", mode, 3'b000);
      chk("rst_src", src, 2'b01);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ack", cmd_ack, 1'b0);

      // Follow: fwd straight out of STOP
      rst = 1'b1;
      tick();
      chk("follow_fwd", mode, 3'b011);
      chk("follow_src", src, 2'b01);

      // Follow fwd -> left passes through 4 dead cycles
      ir_r = 1'b0;
      tick();
      chk("follow_dead0", mode, 3'b000);
      ticks(3);
      chk("follow_dead3", mode, 3'b000);
      tick();
      chk("follow_left", mode, 3'b001);
      ir_l = 1'b0;
      tick();
      chk("follow_lost", mode, 3'b000);

      // Distance window boundaries
      ir_l = 1'b1; ir_r = 1'b1; distance = 20'd15;
      tick();
      chk("near_15", mode, 3'b000);
      distance = 20'd16;
      tick();
      chk("near_16", mode, 3'b011);
      distance = 20'd60;
      tick();
      chk("far_60", mode, 3'b000);
      distance = 20'd59;
      tick();
      chk("far_59", mode, 3'b011);
      ir_l = 1'b0; ir_r = 1'b0;
      tick();
      chk("ir_none", mode, 3'b000);

      // Speech: timed left turn
      sw = 2'b10; distance = 20'd50;
      tick();
      chk("sw_speech", src, 2'b10);
      sw = 2'b00;
      send(8'd247);
      chk("turn_ack", cmd_ack, 1'b1);
      chk("turn_mode", mode, 3'b001);
      chk("turn_busy", busy, 1'b1);
      tick();
      chk("turn_ack_pulse", cmd_ack, 1'b0);
      ticks(6);
      chk("turn_last_mode", mode, 3'b001);
      chk("turn_last_busy", busy, 1'b1);
      tick();
      chk("turn_end_mode", mode, 3'b000);
      chk("turn_end_busy", busy, 1'b0);
      tick();
      chk("turn_stays_stop", mode, 3'b000);

      // Speech fwd -> back through dead time
      send(8'd111);
      chk("fwd_mode", mode, 3'b011);
      tick();
      chk("fwd_hold", mode, 3'b011);
      send(8'd251);
      chk("fb_dead0", mode, 3'b000);
      ticks(3);
      chk("fb_dead3", mode, 3'b000);
      tick();
      chk("back_mode", mode, 3'b100);

      // Unknown byte stops without ack
      send(8'd77);
      chk("unk_mode", mode, 3'b000);
      chk("unk_ack", cmd_ack, 1'b0);

      // Safety stop is sticky
      send(8'd111);
      chk("safe_fwd", mode, 3'b011);
      distance = 20'd20;
      tick();
      chk("safe_stop", mode, 3'b000);
      distance = 20'd50;
      ticks(2);
      chk("safe_sticky", mode, 3'b000);

      // Same-direction turn at count 3 extends the turn
      send(8'd247);
      chk("ext_first_ack", cmd_ack, 1'b1);
      ticks(3);
      send(8'd247);
      chk("ext_second_ack", cmd_ack, 1'b1);
      chk("ext_mode", mode, 3'b001);
      ticks(7);
      chk("ext_last", mode, 3'b001);
      tick();
      chk("ext_end", mode, 3'b000);

      // Reset mid-TURN
      send(8'd255);
      chk("right_mode", mode, 3'b010);
      chk("right_busy", busy, 1'b1);
      rst = 1'b0;
      tick();
      chk("rst_turn_mode", mode, 3'b000);
      chk("rst_turn_busy", busy, 1'b0);
      chk("rst_turn_src", src, 2'b01);
      rst = 1'b1;

      // Reset mid-DEAD, then left must come straight from STOP
      sw = 2'b01; distance = 20'd30; ir_l = 1'b1; ir_r = 1'b1;
      tick();
      chk("pre_dead_fwd", mode, 3'b011);
      ir_r = 1'b0;
      tick();
      chk("in_dead", mode, 3'b000);
      rst = 1'b0;
      tick();
      chk("rst_dead_mode", mode, 3'b000);
      rst = 1'b1;
      tick();
      chk("post_rst_left", mode, 3'b001);

      // sw wins over a same-cycle source command
      send(8'd50);
      chk("conflict_src", src, 2'b01);
      chk("conflict_ack", cmd_ack, 1'b1);
      sw = 2'b00;
      send(8'd50);
      chk("cmd_speech_src", src, 2'b10);
      chk("src_chg_stop", mode, 3'b000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
